// File: rtl/ay_multichip_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ay_seq_pkg : shared types and control-code constants for the AY sequencer
// Revision   : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

package ay_seq_pkg;

  typedef enum logic [1:0] {
    CYC_IDLE  = 2'b00,
    CYC_READ  = 2'b01,
    CYC_WRITE = 2'b10,
    CYC_ADDR  = 2'b11
  } cyc_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_WAITEND = 3'd4
  } state_t;

  localparam logic [3:0] CTRL_NIBBLE     = 4'hF;
  localparam int         CTRL_SAA_BIT    = 3;
  localparam int         CTRL_RDMODE_BIT = 1;

  function automatic logic is_ctrl(input logic [7:0] v);
    return v[7:4] == CTRL_NIBBLE;
  endfunction

  // YM index is {~bit2, bit0} so the historic 0xFE/0xFF codes map to chips 0/1
  function automatic logic [1:0] ctrl_ym_idx(input logic [7:0] v);
    return {~v[2], v[0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ay_multichip_sequencer_if.sv
// ---------------------------------------------------------------------------
// ay_seq_if : AY socket side and internal YM/SAA bus of the sequencer
// Revision  : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface ay_seq_if #(
  parameter int NUM_YM = 2
) ();

  logic              bdir, bc1, bc2, a8, a9_n;
  logic [7:0]        ayd_i;
  logic [7:0]        ayd_o;
  logic              ayd_oe;
  logic              mode_enable_saa, mode_enable_ymfm;
  logic [7:0]        d_i;
  logic [7:0]        d_o;
  logic              d_oe;
  logic [NUM_YM-1:0] ymcs_n;
  logic              ymrd_n, ymwr_n, yma0;
  logic              saacs_n, saawr_n, saaa0;

  // master: the sequencer itself
  modport master (
    input  bdir, bc1, bc2, a8, a9_n, ayd_i, mode_enable_saa, mode_enable_ymfm, d_i,
    output ayd_o, ayd_oe, d_o, d_oe, ymcs_n, ymrd_n, ymwr_n, yma0,
           saacs_n, saawr_n, saaa0
  );

  // slave: AY host plus the FM/SAA chips around it
  modport slave (
    output bdir, bc1, bc2, a8, a9_n, ayd_i, mode_enable_saa, mode_enable_ymfm, d_i,
    input  ayd_o, ayd_oe, d_o, d_oe, ymcs_n, ymrd_n, ymwr_n, yma0,
           saacs_n, saawr_n, saaa0
  );

endinterface

`default_nettype wire

// File: rtl/ay_bus_sync.sv
// ---------------------------------------------------------------------------
// ay_bus_sync : 2-FF sync of AY bus control, stability filter, cycle decode
// Revision    : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ay_bus_sync
  import ay_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bdir,
  input  logic bc1,
  input  logic bc2,
  input  logic a8,
  input  logic a9_n,
  output cyc_t bus_type,
  output logic rec,
  output cyc_t rec_type
);

  logic [4:0] meta;
  logic [4:0] sync;
  logic [1:0] prev;
  logic       bus_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= {bdir, bc1, bc2, a8, a9_n};
      sync <= meta;
      prev <= sync[4:3];
    end
  end

  assign bus_ok   = sync[2] & sync[1] & ~sync[0];
  assign bus_type = cyc_t'(sync[4:3]);
  assign rec_type = bus_type;
  // a type counts only once it has been seen on two consecutive edges
  assign rec      = bus_ok && (sync[4:3] == prev) && (sync[4:3] != 2'b00);

endmodule

`default_nettype wire

// File: rtl/ay_multichip_sequencer.sv
// ---------------------------------------------------------------------------
// ay_multichip_sequencer : routes AY bus cycles to NUM_YM FM chips or the SAA
// Revision : 1.0 initial release   Option macro: YM_READ_EN (chip reads)
// ---------------------------------------------------------------------------
`default_nettype none

module ay_multichip_sequencer
  import ay_seq_pkg::*;
#(
  parameter int NUM_YM       = 2,
  parameter int SETUP_CYCLES = 1,
  parameter int STB_CYCLES   = 4,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic     fclk,
  input  logic     rst,
  ay_seq_if.master bus
);

  localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STB_LOAD   = 4'(STB_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYCLES - 1);
  localparam logic [2:0] NUM_YM_W   = 3'(NUM_YM);

  cyc_t   bus_type, rec_type;
  logic   rec;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic       acc_saa, acc_saa_nxt;
  logic [1:0] acc_idx, acc_idx_nxt;
  logic       acc_rd, acc_rd_nxt;

  logic       sel_saa, sel_rdmode;
  logic [1:0] sel_idx;

  logic [NUM_YM-1:0] ymcs_n_r, ymcs_nxt;
  logic ymwr_n_r, ymwr_nxt, ymrd_n_r, ymrd_nxt;
  logic saacs_n_r, saacs_nxt, saawr_n_r, saawr_nxt;
  logic d_oe_r, d_oe_nxt;
  logic yma0_r, saaa0_r;
  logic [7:0] d_o_r;

  logic       ctrl_code, read_ok, start, ctrl_hit, idx_ok;
  logic [1:0] ctrl_idx;

  ay_bus_sync u_sync (
    .clk      (fclk),
    .rst      (rst),
    .bdir     (bus.bdir),
    .bc1      (bus.bc1),
    .bc2      (bus.bc2),
    .a8       (bus.a8),
    .a9_n     (bus.a9_n),
    .bus_type (bus_type),
    .rec      (rec),
    .rec_type (rec_type)
  );

  assign ctrl_code = (rec_type == CYC_ADDR) && is_ctrl(bus.ayd_i);
`ifdef YM_READ_EN
  assign read_ok   = ~sel_saa;
`else
  assign read_ok   = 1'b0;
`endif
  assign start     = (state == ST_IDLE) && rec && !ctrl_code &&
                     !((rec_type == CYC_READ) && !read_ok);
  assign ctrl_hit  = (state == ST_IDLE) && rec && ctrl_code;
  assign ctrl_idx  = ctrl_ym_idx(bus.ayd_i);
  assign idx_ok    = ({1'b0, ctrl_idx} < NUM_YM_W) &&
                     (bus.mode_enable_ymfm || (ctrl_idx == 2'd0));

  // FSM: state register (outputs are registered from their next values)
  always_ff @(posedge fclk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc_saa   <= 1'b0;
      acc_idx   <= '0;
      acc_rd    <= 1'b0;
      ymcs_n_r  <= '1;
      ymwr_n_r  <= 1'b1;
      ymrd_n_r  <= 1'b1;
      saacs_n_r <= 1'b1;
      saawr_n_r <= 1'b1;
      d_oe_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      acc_saa   <= acc_saa_nxt;
      acc_idx   <= acc_idx_nxt;
      acc_rd    <= acc_rd_nxt;
      ymcs_n_r  <= ymcs_nxt;
      ymwr_n_r  <= ymwr_nxt;
      ymrd_n_r  <= ymrd_nxt;
      saacs_n_r <= saacs_nxt;
      saawr_n_r <= saawr_nxt;
      d_oe_r    <= d_oe_nxt;
    end
  end

  // FSM: next state, shared down-counter and latched access target
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    acc_saa_nxt = acc_saa;
    acc_idx_nxt = acc_idx;
    acc_rd_nxt  = acc_rd;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt   = ST_SETUP;
          cnt_nxt     = SETUP_LOAD;
          acc_saa_nxt = sel_saa;
          acc_idx_nxt = sel_idx;
          acc_rd_nxt  = (rec_type == CYC_READ);
        end else if (rec) begin
          state_nxt = ST_WAITEND;
        end
      end
      ST_SETUP: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_STROBE;
          cnt_nxt   = STB_LOAD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt == 4'd0) state_nxt = ST_WAITEND;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ST_WAITEND: begin
        if (bus_type == CYC_IDLE) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM: output decode of the upcoming state
  always_comb begin
    logic cs_act, stb;
    cs_act   = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) ||
               (state_nxt == ST_HOLD);
    stb      = (state_nxt == ST_STROBE);
    ymcs_nxt = '1;
    for (int i = 0; i < NUM_YM; i++) begin
      if (cs_act && !acc_saa_nxt && (acc_idx_nxt == 2'(i))) ymcs_nxt[i] = 1'b0;
    end
    ymwr_nxt  = ~(stb & ~acc_saa_nxt & ~acc_rd_nxt);
`ifdef YM_READ_EN
    ymrd_nxt  = ~(stb & ~acc_saa_nxt & acc_rd_nxt);
`else
    ymrd_nxt  = 1'b1;
`endif
    saacs_nxt = ~(cs_act & acc_saa_nxt);
    saawr_nxt = ~(stb & acc_saa_nxt);
    d_oe_nxt  = cs_act & ~acc_rd_nxt;
  end

  // Selection, address line and write data
  always_ff @(posedge fclk) begin
    if (rst) begin
      sel_saa    <= 1'b0;
      sel_idx    <= '0;
      sel_rdmode <= 1'b1;
      yma0_r     <= 1'b0;
      saaa0_r    <= 1'b0;
      d_o_r      <= '0;
    end else begin
      if (ctrl_hit) begin
        if (!bus.ayd_i[CTRL_SAA_BIT]) begin
          if (bus.mode_enable_saa) sel_saa <= 1'b1;
        end else if (idx_ok) begin
          sel_saa    <= 1'b0;
          sel_idx    <= ctrl_idx;
          sel_rdmode <= bus.ayd_i[CTRL_RDMODE_BIT];
        end
      end
      if (start) begin
        if (sel_saa) saaa0_r <= (rec_type == CYC_ADDR);
        else         yma0_r  <= (rec_type == CYC_WRITE) ||
                                ((rec_type == CYC_READ) && sel_rdmode);
        if (rec_type != CYC_READ) d_o_r <= bus.ayd_i;
      end
    end
  end

`ifdef YM_READ_EN
  logic [7:0] ayd_o_r;
  logic       ayd_oe_r, rd_pend;

  // read data is latched as the strobe ends and driven once the FSM moves on
  always_ff @(posedge fclk) begin
    if (rst) begin
      ayd_o_r  <= '0;
      ayd_oe_r <= 1'b0;
      rd_pend  <= 1'b0;
    end else begin
      if ((state == ST_STROBE) && (cnt == 4'd0) && acc_rd) begin
        ayd_o_r <= bus.d_i;
        rd_pend <= 1'b1;
      end else if (bus_type != CYC_READ) begin
        rd_pend <= 1'b0;
      end
      ayd_oe_r <= rd_pend && (bus_type == CYC_READ);
    end
  end

  assign bus.ayd_o  = ayd_o_r;
  assign bus.ayd_oe = ayd_oe_r;
`else
  assign bus.ayd_o  = 8'h00;
  assign bus.ayd_oe = 1'b0;
`endif

  assign bus.ymcs_n  = ymcs_n_r;
  assign bus.ymwr_n  = ymwr_n_r;
  assign bus.ymrd_n  = ymrd_n_r;
  assign bus.yma0    = yma0_r;
  assign bus.saacs_n = saacs_n_r;
  assign bus.saawr_n = saawr_n_r;
  assign bus.saaa0   = saaa0_r;
  assign bus.d_o     = d_o_r;
  assign bus.d_oe    = d_oe_r;

endmodule

`default_nettype wire

// File: tb/tb_ay_multichip_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ay_multichip_sequencer : directed self-checking bench for the sequencer
// Revision : 1.0 initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ay_multichip_sequencer;

  localparam int NUM_YM = 2;
  localparam logic [1:0] T_READ = 2'b01, T_WRITE = 2'b10, T_ADDR = 2'b11;

  logic fclk = 1'b0;
  logic rst  = 1'b1;
  always #5 fclk = ~fclk;

  ay_seq_if #(.NUM_YM(NUM_YM)) bus ();

  ay_multichip_sequencer #(
    .NUM_YM(NUM_YM), .SETUP_CYCLES(1), .STB_CYCLES(4), .HOLD_CYCLES(1)
  ) dut (
    .fclk (fclk),
    .rst  (rst),
    .bus  (bus)
  );

  // chip model: data register on a0=1, status on a0=0
  logic [7:0] rddat  = 8'hA5;
  logic [7:0] rdstat = 8'h80;
  assign bus.d_i = (bus.ymrd_n == 1'b0) ? (bus.yma0 ? rddat : rdstat) : 8'h00;

  int total = 0;
  int bad   = 0;

  int         ym_wr_cnt = 0, ym_wr_len = 0, ym_rd_cnt = 0, ym_rd_len = 0;
  int         saa_wr_cnt = 0, saa_wr_len = 0, ym_cs_cycles = 0;
  logic       prev_ymwr = 1'b1, prev_ymrd = 1'b1, prev_saawr = 1'b1;
  logic       ym_wr_a0, ym_wr_doe, ym_rd_a0, saa_wr_a0, saa_wr_cs;
  logic [7:0] ym_wr_d, saa_wr_d;
  logic [1:0] ym_wr_cs, ym_rd_cs;

  always @(negedge fclk) begin
    if (bus.ymcs_n != 2'b11) ym_cs_cycles <= ym_cs_cycles + 1;
    if (!bus.ymwr_n) begin
      if (prev_ymwr) begin
        ym_wr_cnt <= ym_wr_cnt + 1;
        ym_wr_len <= 1;
        ym_wr_a0  <= bus.yma0;
        ym_wr_d   <= bus.d_o;
        ym_wr_doe <= bus.d_oe;
        ym_wr_cs  <= bus.ymcs_n;
      end else ym_wr_len <= ym_wr_len + 1;
    end
    if (!bus.ymrd_n) begin
      if (prev_ymrd) begin
        ym_rd_cnt <= ym_rd_cnt + 1;
        ym_rd_len <= 1;
        ym_rd_a0  <= bus.yma0;
        ym_rd_cs  <= bus.ymcs_n;
      end else ym_rd_len <= ym_rd_len + 1;
    end
    if (!bus.saawr_n) begin
      if (prev_saawr) begin
        saa_wr_cnt <= saa_wr_cnt + 1;
        saa_wr_len <= 1;
        saa_wr_a0  <= bus.saaa0;
        saa_wr_d   <= bus.d_o;
        saa_wr_cs  <= bus.saacs_n;
      end else saa_wr_len <= saa_wr_len + 1;
    end
    prev_ymwr  <= bus.ymwr_n;
    prev_ymrd  <= bus.ymrd_n;
    prev_saawr <= bus.saawr_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  task automatic bus_start(input logic [1:0] typ, input logic [7:0] dat, input logic bc2v);
    @(negedge fclk);
    bus.ayd_i = dat;
    bus.bc2   = bc2v;
    {bus.bdir, bus.bc1} = typ;
  endtask

  task automatic bus_end();
    @(negedge fclk);
    {bus.bdir, bus.bc1} = 2'b00;
    bus.bc2 = 1'b1;
    tick(6);
  endtask

  task automatic cycle(input logic [1:0] typ, input logic [7:0] dat);
    bus_start(typ, dat, 1'b1);
    tick(16);
    bus_end();
  endtask

  int wr0, rd0, saa0, cs0;
  logic seen;

  initial begin
    bus.bdir = 0; bus.bc1 = 0; bus.bc2 = 1; bus.a8 = 1; bus.a9_n = 0;
    bus.ayd_i = 8'h00; bus.mode_enable_saa = 1; bus.mode_enable_ymfm = 1;
    tick(4);
    check("rst_ymcs", bus.ymcs_n, 2'b11);
    check("rst_strobes", {bus.ymwr_n, bus.ymrd_n, bus.saacs_n, bus.saawr_n}, 4'hF);
    check("rst_a0_oe", {bus.yma0, bus.saaa0, bus.d_oe, bus.ayd_oe}, 4'h0);
    check("rst_data", {bus.d_o, bus.ayd_o}, 16'h0000);
    @(negedge fclk); rst = 1'b0;
    tick(3);

    // SAA: control F7, address 5A, data 3C
    wr0 = ym_wr_cnt; saa0 = saa_wr_cnt; cs0 = ym_cs_cycles;
    cycle(T_ADDR, 8'hF7);
    check("ctrl_f7_no_fwd", saa_wr_cnt - saa0, 0);
    cycle(T_ADDR, 8'h5A);
    check("saa_adr_cnt", saa_wr_cnt - saa0, 1);
    check("saa_adr", {saa_wr_cs, saa_wr_a0, saa_wr_d}, {1'b0, 1'b1, 8'h5A});
    cycle(T_WRITE, 8'h3C);
    check("saa_dat", {saa_wr_cs, saa_wr_a0, saa_wr_d}, {1'b0, 1'b0, 8'h3C});
    check("saa_len", saa_wr_len, 4);
    check("saa_ym_quiet", (ym_cs_cycles - cs0) + (ym_wr_cnt - wr0), 0);

    // YM chip 0: control FE, address 27, data 81
    cycle(T_ADDR, 8'hFE);
    wr0 = ym_wr_cnt;
    cycle(T_ADDR, 8'h27);
    check("ym_adr", {ym_wr_cs, ym_wr_a0, ym_wr_doe, ym_wr_d}, {2'b10, 1'b0, 1'b1, 8'h27});
    check("ym_adr_len", ym_wr_len, 4);
    cycle(T_WRITE, 8'h81);
    check("ym_dat", {ym_wr_cs, ym_wr_a0, ym_wr_d}, {2'b10, 1'b1, 8'h81});
    check("ym_dat_len", ym_wr_len, 4);
    check("ym_wr_cnt", ym_wr_cnt - wr0, 2);
    check("ym_idle_after", {bus.ymcs_n, bus.ymwr_n, bus.d_oe}, {2'b11, 1'b1, 1'b0});

    // chip 1 reads: data register then status
    cycle(T_ADDR, 8'hFF);
    rd0 = ym_rd_cnt;
    bus_start(T_READ, 8'h00, 1'b1);
    tick(16);
`ifdef YM_READ_EN
    check("rd_cnt", ym_rd_cnt - rd0, 1);
    check("rd_len", ym_rd_len, 4);
    check("rd_a0_cs", {ym_rd_a0, ym_rd_cs}, {1'b1, 2'b01});
    check("rd_dat_oe", {bus.ayd_oe, bus.ayd_o}, {1'b1, 8'hA5});
`else
    check("rd_none", ym_rd_cnt - rd0, 0);
    check("rd_oe_off", {bus.ayd_oe, bus.ayd_o}, 9'h000);
`endif
    bus_end();
    check("rd_oe_release", bus.ayd_oe, 1'b0);
    cycle(T_ADDR, 8'hFD);
    bus_start(T_READ, 8'h00, 1'b1);
    tick(16);
`ifdef YM_READ_EN
    check("rd_stat", {ym_rd_a0, bus.ayd_oe, bus.ayd_o}, {1'b0, 1'b1, 8'h80});
`else
    check("rd_stat_off", {bus.ymrd_n, bus.ayd_oe, bus.ayd_o}, {1'b1, 1'b0, 8'h00});
`endif
    bus_end();

    // control FA names chip 2, which does not exist: selection stays chip 1
    cycle(T_ADDR, 8'hFA);
    cycle(T_WRITE, 8'h11);
    check("fa_ignored", {ym_wr_cs, ym_wr_a0, ym_wr_d}, {2'b01, 1'b1, 8'h11});

    // SAA disabled by strap
    bus.mode_enable_saa = 1'b0;
    saa0 = saa_wr_cnt;
    cycle(T_ADDR, 8'hF7);
    cycle(T_WRITE, 8'h22);
    check("saa_off_saa", saa_wr_cnt - saa0, 0);
    check("saa_off_ym", {ym_wr_cs, ym_wr_d}, {2'b01, 8'h22});
    bus.mode_enable_saa = 1'b1;

    // bc2 low disqualifies the cycle
    wr0 = ym_wr_cnt; saa0 = saa_wr_cnt;
    bus_start(T_WRITE, 8'h33, 1'b0);
    tick(16);
    bus_end();
    check("bc2_low", (ym_wr_cnt - wr0) + (saa_wr_cnt - saa0), 0);

    // reset in the middle of a strobe
    bus_start(T_WRITE, 8'h55, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (!bus.ymwr_n) seen = 1'b1;
    end
    check("rst_wait_strobe", seen, 1'b1);
    @(negedge fclk); rst = 1'b1;
    tick(1);
    check("rst_mid_strobe", {bus.ymcs_n, bus.ymwr_n, bus.d_oe}, {2'b11, 1'b1, 1'b0});
    @(negedge fclk); {bus.bdir, bus.bc1} = 2'b00;
    tick(4);
    @(negedge fclk); rst = 1'b0;
    tick(4);
    cycle(T_WRITE, 8'h44);
    check("post_rst_chip0", {ym_wr_cs, ym_wr_a0, ym_wr_d}, {2'b10, 1'b1, 8'h44});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/ay_multichip_sequencer.md
Name: ay_multichip_sequencer

Overview:
- Synchronous successor to the TurboFMpro bus glue.
- Samples AY-style bus control (bdir/bc1/bc2/a8/a9_n) on fclk and decodes address-latch, data-write and read cycles.
- Routes each cycle to one of NUM_YM FM chips or the SAA, generating timed cs/rd/wr/a0 strobes and read-data turnaround.
- Sits between the AY socket and the internal YM/SAA data bus d.

Parameters:
- NUM_YM, 2, number of YM chips, legal range 1..4.
- SETUP_CYCLES, 1, fclk cycles with cs_n low and a0/data valid before the strobe, legal range 1..15.
- STB_CYCLES, 4, fclk cycles with wr_n/rd_n low, legal range 1..15.
- HOLD_CYCLES, 1, fclk cycles with cs_n low after the strobe rises, legal range 1..15.

Ports:
- fclk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- bdir, bc1, bc2, a8, a9_n  in  1 each  AY bus control, asynchronous to fclk.
- ayd_i  in  8  AY data bus input.
- ayd_o  out  8  read data returned to the AY bus.
- ayd_oe  out  1  drive enable for ayd_o.
- mode_enable_saa, mode_enable_ymfm  in  1 each  static mode straps.
- d_i  in  8  internal bus input.
- d_o  out  8  internal bus output.
- d_oe  out  1  drive enable for d_o.
- ymcs_n  out  NUM_YM  per-chip chip select.
- ymrd_n, ymwr_n, yma0  out  1 each  shared YM strobes and address line.
- saacs_n, saawr_n, saaa0  out  1 each  SAA strobes and address line.

Behaviour:
- Reset values: all *cs_n, ymrd_n, ymwr_n and saawr_n are 1. yma0, saaa0, d_oe and ayd_oe are 0. d_o and ayd_o are 0. Selection is chip 0 in register-read mode (equivalent to control 0xFE).
- Reset asserted mid-cycle: every strobe deasserts on the next edge and the FSM returns to IDLE.
- Input sync: bdir, bc1, bc2, a8 and a9_n pass through 2-FF synchronisers.
- Bus qualify: bus_ok = bc2 & a8 & ~a9_n. A cycle type is recognised when the synchronised {bdir,bc1} is stable for 2 consecutive fclk and bus_ok=1. Types: 11 = ADDR, 10 = WRITE, 01 = READ, 00 = IDLE.
- ayd_i is captured on the recognition edge.
- Control codes: an ADDR value matching 1111_xxxx is a control code and is not forwarded to any chip.
  - bit3=0 selects the SAA. Ignored if mode_enable_saa=0.
  - bit3=1 selects YM index {~bit2, bit0}, with bit1 as read mode (1 = data register, 0 = status).
  - Ignored if index ≥ NUM_YM.
  - If mode_enable_ymfm=0, only index 0 is accepted.
- Routing: YM ADDR uses a0=0; YM WRITE uses a0=1; YM READ uses a0=read mode. SAA ADDR uses a0=1; SAA WRITE uses a0=0. SAA READ is ignored: no strobes, ayd_oe stays 0.
- FSM states: IDLE → SETUP → STROBE → HOLD → WAITEND → IDLE.
  - IDLE→SETUP on a recognised non-control cycle. On that edge, a0 is driven, the selected cs_n goes low, and d_o/d_oe are set for writes only.
  - SETUP lasts SETUP_CYCLES, STROBE lasts STB_CYCLES (wr_n or rd_n low), HOLD lasts HOLD_CYCLES.
  - WAITEND releases cs_n and d_oe, then waits for synchronised {bdir,bc1}=00 before returning to IDLE.
  - A control code goes straight to WAITEND.
  - A new cycle type seen before IDLE is ignored: one access per bus cycle.
- Read data: d_i is latched into ayd_o on the last STROBE cycle. ayd_oe=1 from the following edge until the synchronised bus leaves READ.
- Counter: a single 4-bit down-counter is shared by SETUP, STROBE and HOLD. Minimum access length is SETUP+STB+HOLD+1 fclk.

Optional Feature:
- Macro YM_READ_EN.
  - Defined: READ cycles are executed as above.
  - Undefined: READ cycles go straight to WAITEND, ymrd_n stays 1, ayd_oe is tied 0 and ayd_o is tied 0.

Decomposition:
- Shared package ay_seq_pkg holds:
  - the cycle-type enum (IDLE, ADDR, WRITE, READ);
  - the FSM state enum;
  - control-code constants CTRL_NIBBLE=4'hF, CTRL_SAA_BIT=3, CTRL_RDMODE_BIT=1.
- One sub-module ay_bus_sync covers the 2-FF sync, the 2-cycle stability filter and cycle-type decode.

Test Plan:
- Control 0xF7, then ADDR 0x5A, then WRITE 0x3C → SAA receives adr=0x5A with saaa0=1 and dat=0x3C with saaa0=0. ymcs_n stays all 1.
- Control 0xFE, then ADDR 0x27, then WRITE 0x81 → ymcs_n[0] pulses. ymwr_n is low for exactly STB_CYCLES=4 fclk. The chip sees adr=0x27 with a0=0 and wrdat=0x81 with a0=1.
- Control 0xFF with rddat=0xA5, then READ → yma0=1, ymrd_n pulses, ayd_o=0xA5 with ayd_oe=1 until bdir/bc1 return to 00. Control 0xFD with rdstat=0x80 → ayd_o=0x80.
- With NUM_YM=2, control 0xFA → ignored, selection unchanged. With mode_enable_saa=0, control 0xF7 → SAA never selected.
- bc2=0 during a WRITE → no strobes generated.
- rst asserted during STROBE → all cs_n/wr_n are 1 on the next edge. The next WRITE goes to chip 0.
